// File: rtl/pipeline_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_if
// Bundle of the hazard/stall controller's handshake and control signals.
//   master : the pipeline datapath side; drives cache handshakes, hazard
//            operands and branch resolution, receives enables/flushes.
//   slave  : the controller (pipeline_ctrl).
// Parameters:
//   XLEN   PC / redirect target width
//   CNT_W  width of the saturating performance counters
// -----------------------------------------------------------------------------
interface pipeline_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  // Cache handshakes
  logic             i_req;
  logic             i_resp;
  logic             d_req;
  logic             d_resp;
  // Hazard operands
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_is_load;
  // Branch resolution
  logic             ex_br_taken;
  logic [XLEN-1:0]  ex_target;
  // Controls back to the datapath
  logic             load_pc;
  logic [1:0]       pc_sel;
  logic [XLEN-1:0]  redirect_pc;
  logic             load_if_id;
  logic             load_id_ex;
  logic             load_ex_mem;
  logic             load_mem_wb;
  logic             flush_if_id;
  logic             flush_id_ex;
  // Performance counters
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output i_req, i_resp, d_req, d_resp,
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
    output ex_br_taken, ex_target,
    input  load_pc, pc_sel, redirect_pc,
    input  load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
    input  flush_if_id, flush_id_ex,
    input  stall_cycles, flush_events
  );

  modport slave (
    input  i_req, i_resp, d_req, d_resp,
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
    input  ex_br_taken, ex_target,
    output load_pc, pc_sel, redirect_pc,
    output load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
    output flush_if_id, flush_id_ex,
    output stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Hazard and stall controller for a 5-stage pipeline. Produces the PC and
// pipe-register load enables plus IF/ID and ID/EX bubble controls, sequencing
// around I-cache misses, D-cache misses, load-use hazards and taken branches.
// A branch that resolves while a fetch is outstanding is parked in
// redirect_pc and applied once the fetch returns.
// Ports:
//   clk    clock, rising edge
//   reset  asynchronous active-low reset
//   bus    pipeline_ctrl_if.slave (handshakes, hazard operands, controls,
//          counters)
// All controls are combinational (same-cycle decisions); only the pending
// redirect and the two counters are registered.
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int CNT_W = 32,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  pipeline_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    PC_SEQ      = 2'd0,
    PC_BRANCH   = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

  logic             pend_q, pend_d;
  logic [XLEN-1:0]  redir_q, redir_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic             mem_busy;
  logic             fetch_busy;
  logic             load_use;

  pc_sel_e          pc_sel;
  logic             load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic             flush_if_id, flush_id_ex;

  assign mem_busy   = bus.d_req & ~bus.d_resp;
  assign fetch_busy = bus.i_req & ~bus.i_resp;
  assign load_use   = bus.ex_is_load && (bus.ex_rd != 5'd0) &&
                      ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                       (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

  always_comb begin
    // NOTE: every output and next-state gets a default before the priority
    // chain, so no path leaves a signal unassigned and no latch is inferred.
    load_pc     = 1'b0;
    load_if_id  = 1'b0;
    load_id_ex  = 1'b0;
    load_ex_mem = 1'b0;
    load_mem_wb = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    pc_sel      = PC_SEQ;
    pend_d      = pend_q;
    redir_d     = redir_q;

    if (!reset) begin
      // Everything held at zero while in reset.
    end else if (mem_busy) begin
      // Full freeze; branch and load-use are re-evaluated once MEM drains.
    end else if (bus.ex_br_taken && !fetch_busy) begin
      load_pc     = 1'b1;
      load_if_id  = 1'b1;
      load_id_ex  = 1'b1;
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      pc_sel      = PC_BRANCH;
      // A fresh redirect supersedes any older parked target.
      pend_d      = 1'b0;
    end else if (bus.ex_br_taken && fetch_busy) begin
      // PC cannot move until the fetch returns: park the target, bubble EX.
      load_id_ex  = 1'b1;
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
      flush_id_ex = 1'b1;
      pend_d      = 1'b1;
      redir_d     = bus.ex_target;
    end else if (fetch_busy || load_use) begin
      // Hold front end, insert one bubble; the load moves on to MEM.
      load_id_ex  = 1'b1;
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
      flush_id_ex = 1'b1;
    end else begin
      load_pc     = 1'b1;
      load_if_id  = 1'b1;
      load_id_ex  = 1'b1;
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
      if (pend_q) begin
        // The instruction that just arrived is wrong-path: drop it.
        pc_sel      = PC_REDIRECT;
        flush_if_id = 1'b1;
        pend_d      = 1'b0;
      end
    end
  end

  // Saturating counters: stop at all-ones instead of wrapping.
  assign stall_d = (!load_pc && (stall_q != '1)) ? stall_q + 1'b1 : stall_q;
  assign flush_d = (flush_if_id && (flush_q != '1)) ? flush_q + 1'b1 : flush_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q  <= 1'b0;
      redir_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      pend_q  <= pend_d;
      redir_q <= redir_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign bus.load_pc      = load_pc;
  assign bus.pc_sel       = pc_sel;
  assign bus.redirect_pc  = redir_q;
  assign bus.load_if_id   = load_if_id;
  assign bus.load_id_ex   = load_id_ex;
  assign bus.load_ex_mem  = load_ex_mem;
  assign bus.load_mem_wb  = load_mem_wb;
  assign bus.flush_if_id  = flush_if_id;
  assign bus.flush_id_ex  = flush_id_ex;
  assign bus.stall_cycles = stall_q;
  assign bus.flush_events = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
// Directed bench for pipeline_ctrl. Inputs change on the falling edge and the
// combinational controls are sampled 1 time unit later. Control outputs are
// packed as {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
// flush_if_id, flush_id_ex, pc_sel[1:0]}. The counters are built with a small
// width so saturation is reachable.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Hand-derived control vectors
  localparam logic [8:0] V_ZERO   = 9'b00000_00_00; // reset / full freeze
  localparam logic [8:0] V_RUN    = 9'b11111_00_00; // normal advance
  localparam logic [8:0] V_BUBBLE = 9'b00111_01_00; // hold front, bubble EX
  localparam logic [8:0] V_BRANCH = 9'b11111_11_01; // taken branch, pc_sel=1
  localparam logic [8:0] V_REDIR  = 9'b11111_10_10; // parked redirect, pc_sel=2

  logic clk;
  logic reset;

  pipeline_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  pipeline_ctrl #(.CNT_W(CNT_W), .XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [8:0]       exp_vec;
  logic [CNT_W-1:0] exp_stall;
  logic [CNT_W-1:0] exp_flush;

  function automatic logic [8:0] outs();
    return {bus.load_pc, bus.load_if_id, bus.load_id_ex, bus.load_ex_mem,
            bus.load_mem_wb, bus.flush_if_id, bus.flush_id_ex, bus.pc_sel};
  endfunction

  task automatic idle();
    bus.i_req       = 1'b0;
    bus.i_resp      = 1'b0;
    bus.d_req       = 1'b0;
    bus.d_resp      = 1'b0;
    bus.id_rs1      = 5'd0;
    bus.id_rs2      = 5'd0;
    bus.id_use_rs1  = 1'b0;
    bus.id_use_rs2  = 1'b0;
    bus.ex_rd       = 5'd0;
    bus.ex_is_load  = 1'b0;
    bus.ex_br_taken = 1'b0;
    bus.ex_target   = '0;
  endtask

  // Advance one clock; the counter model follows the expected controls.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      if (!exp_vec[8] && exp_stall != CNT_MAX) exp_stall = exp_stall + 1'b1;
      if (exp_vec[3] && exp_flush != CNT_MAX) exp_flush = exp_flush + 1'b1;
    end else begin
      exp_stall = '0;
      exp_flush = '0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    exp_stall = '0;
    exp_flush = '0;
    idle();
    bus.i_req = 1'b1; bus.d_req = 1'b1; bus.ex_br_taken = 1'b1;
    bus.ex_is_load = 1'b1; bus.ex_rd = 5'd3; bus.id_rs1 = 5'd3;
    bus.id_use_rs1 = 1'b1; bus.ex_target = 32'h44;
    @(negedge clk);
    #1;
    exp_vec = V_ZERO;
    checks++;
    if (outs() !== exp_vec) begin
      failures++;
      $display("FAIL reset_ctl: got %b expected %b", outs(), exp_vec);
    end
    checks++;
    if (bus.stall_cycles !== '0 || bus.flush_events !== '0 || bus.redirect_pc !== '0) begin
      failures++;
      $display("FAIL reset_state: got stall=%0d flush=%0d rpc=%h expected 0/0/0",
               bus.stall_cycles, bus.flush_events, bus.redirect_pc);
    end
    tick();
    reset = 1'b1;
    idle();
    #1;
    exp_vec = V_RUN;
    checks++;
    if (outs() !== exp_vec) begin
      failures++;
      $display("FAIL reset_release: got %b expected %b", outs(), exp_vec);
    end
    tick();
  endtask

  task automatic test_dmiss();
    logic [CNT_W-1:0] base;
    base = exp_stall;
    for (int i = 0; i < 3; i++) begin
      idle();
      bus.d_req = 1'b1;
      #1;
      exp_vec = V_ZERO;
      checks++;
      if (outs() !== exp_vec) begin
        failures++;
        $display("FAIL dmiss_freeze%0d: got %b expected %b", i, outs(), exp_vec);
      end
      tick();
    end
    idle();
    bus.d_req = 1'b1; bus.d_resp = 1'b1;
    #1;
    exp_vec = V_RUN;
    checks++;
    if (outs() !== exp_vec) begin
      failures++;
      $display("FAIL dmiss_resume: got %b expected %b", outs(), exp_vec);
    end
    checks++;
    if (bus.stall_cycles !== exp_stall || exp_stall !== base + 4'd3) begin
      failures++;
      $display("FAIL dmiss_stall_cnt: got %0d expected %0d", bus.stall_cycles, base + 4'd3);
    end
    tick();
  endtask

  task automatic test_load_use();
    // rs2 hazard: one bubble, then the load has moved on.
    idle();
    bus.ex_is_load = 1'b1; bus.ex_rd = 5'd5; bus.id_rs2 = 5'd5; bus.id_use_rs2 = 1'b1;
    #1;
    exp_vec = V_BUBBLE;
    checks++;
    if (outs() !== exp_vec) begin
      failures++;
      $display("FAIL lu_rs2: got %b expected %b", outs(), exp_vec);
    end
    tick();
    bus.ex_is_load = 1'b0;
    #1;
    exp_vec = V_RUN;
    checks++;
    if (outs() !== exp_vec) begin
      failures++;
      $display("FAIL lu_after: got %b expected %b", outs(), exp_vec);
    end
    tick();
    // rs1 hazard
    idle();
    bus.ex_is_load = 1'b1; bus.ex_rd = 5'd7; bus.id_rs1 = 5'd7; bus.id_use_rs1 = 1'b1;
    #1;
    exp_vec = V_BUBBLE;
    checks++;
    if (outs() !== exp_vec) begin
      failures++;
      $display("FAIL lu_rs1: got %b expected %b", outs(), exp_vec);
    end
    tick();
    // x0 destination never hazards
    idle();
    bus.ex_is_load = 1'b1; bus.ex_rd = 5'd0; bus.id_rs2 = 5'd0; bus.id_use_rs2 = 1'b1;
    #1;
    exp_vec = V_RUN;
    checks++;
    if (outs() !== exp_vec) begin
      failures++;
      $display("FAIL lu_x0: got %b expected %b", outs(), exp_vec);
    end
    tick();
    // Matching register but not read
    idle();
    bus.ex_is_load = 1'b1; bus.ex_rd = 5'd5; bus.id_rs2 = 5'd5; bus.id_use_rs2 = 1'b0;
    #1;
    checks++;
    if (outs() !== exp_vec) begin
      failures++;
      $display("FAIL lu_unused: got %b expected %b", outs(), exp_vec);
    end
    tick();
  endtask

  task automatic test_branch();
    idle();
    bus.ex_br_taken = 1'b1; bus.ex_target = 32'h60;
    // A simultaneous load-use loses to the branch.
    bus.ex_is_load = 1'b1; bus.ex_rd = 5'd9; bus.id_rs1 = 5'd9; bus.id_use_rs1 = 1'b1;
    #1;
    exp_vec = V_BRANCH;
    checks++;
    if (outs() !== exp_vec) begin
      failures++;
      $display("FAIL branch_ctl: got %b expected %b", outs(), exp_vec);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.flush_events !== exp_flush || exp_flush !== 4'd1) begin
      failures++;
      $display("FAIL branch_flush_cnt: got %0d expected 1", bus.flush_events);
    end
    tick();
  endtask

  task automatic test_branch_fetch_miss();
    idle();
    bus.i_req = 1'b1; bus.ex_br_taken = 1'b1; bus.ex_target = 32'h80;
    #1;
    exp_vec = V_BUBBLE;
    checks++;
    if (outs() !== exp_vec) begin
      failures++;
      $display("FAIL bfm_park: got %b expected %b", outs(), exp_vec);
    end
    tick();
    bus.ex_br_taken = 1'b0; bus.ex_target = 32'h0;
    #1;
    checks++;
    if (bus.redirect_pc !== 32'h80 || outs() !== V_BUBBLE) begin
      failures++;
      $display("FAIL bfm_hold: got rpc=%h ctl=%b expected rpc=80 ctl=%b",
               bus.redirect_pc, outs(), V_BUBBLE);
    end
    tick();
    bus.i_resp = 1'b1;
    #1;
    exp_vec = V_REDIR;
    checks++;
    if (outs() !== exp_vec) begin
      failures++;
      $display("FAIL bfm_redirect: got %b expected %b", outs(), exp_vec);
    end
    tick();
    idle();
    #1;
    exp_vec = V_RUN;
    checks++;
    if (outs() !== exp_vec) begin
      failures++;
      $display("FAIL bfm_cleared: got %b expected %b", outs(), exp_vec);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    // Two branches while the fetch is stuck: the later target wins.
    idle();
    bus.i_req = 1'b1; bus.ex_br_taken = 1'b1; bus.ex_target = 32'hA0;
    exp_vec = V_BUBBLE;
    tick();
    bus.ex_target = 32'hB0;
    tick();
    bus.ex_br_taken = 1'b0; bus.i_resp = 1'b1;
    #1;
    exp_vec = V_REDIR;
    checks++;
    if (bus.redirect_pc !== 32'hB0 || outs() !== exp_vec) begin
      failures++;
      $display("FAIL b2b_overwrite: got rpc=%h ctl=%b expected rpc=b0 ctl=%b",
               bus.redirect_pc, outs(), exp_vec);
    end
    tick();
  endtask

  task automatic test_dmiss_branch_reset();
    idle();
    bus.d_req = 1'b1; bus.ex_br_taken = 1'b1; bus.ex_target = 32'h40;
    #1;
    exp_vec = V_ZERO;
    checks++;
    if (outs() !== exp_vec) begin
      failures++;
      $display("FAIL dbr_freeze: got %b expected %b", outs(), exp_vec);
    end
    tick();
    bus.d_resp = 1'b1;
    #1;
    exp_vec = V_BRANCH;
    checks++;
    if (outs() !== exp_vec) begin
      failures++;
      $display("FAIL dbr_branch: got %b expected %b", outs(), exp_vec);
    end
    tick();
    // Park a redirect, then reset while it is pending.
    idle();
    bus.i_req = 1'b1; bus.ex_br_taken = 1'b1; bus.ex_target = 32'hC0;
    exp_vec = V_BUBBLE;
    tick();
    reset = 1'b0;
    exp_stall = '0;
    exp_flush = '0;
    #1;
    exp_vec = V_ZERO;
    checks++;
    if (outs() !== exp_vec || bus.redirect_pc !== '0 || bus.stall_cycles !== '0) begin
      failures++;
      $display("FAIL dbr_reset: got ctl=%b rpc=%h stall=%0d expected ctl=%b rpc=0 stall=0",
               outs(), bus.redirect_pc, bus.stall_cycles, exp_vec);
    end
    tick();
    reset = 1'b1;
    idle();
    #1;
    exp_vec = V_RUN;
    checks++;
    if (outs() !== exp_vec) begin
      failures++;
      $display("FAIL dbr_after_reset: got %b expected %b", outs(), exp_vec);
    end
    tick();
  endtask

  task automatic test_saturation();
    idle();
    bus.d_req = 1'b1;
    exp_vec = V_ZERO;
    for (int i = 0; i < 20; i++) tick();
    idle();
    #1;
    checks++;
    if (bus.stall_cycles !== CNT_MAX || exp_stall !== CNT_MAX) begin
      failures++;
      $display("FAIL stall_saturate: got %0d expected %0d", bus.stall_cycles, CNT_MAX);
    end
    exp_vec = V_RUN;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    exp_vec = V_ZERO;
    idle();
    test_reset();
    test_dmiss();
    test_load_use();
    test_branch();
    test_branch_fetch_miss();
    test_back_to_back();
    test_dmiss_branch_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Hazard and stall controller for the 5-stage pipeline. It generates the load enables for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipe registers, plus the flush (bubble) controls. It sequences the pipeline around I-cache and D-cache misses, load-use hazards and taken-branch redirects. When a redirect collides with an outstanding fetch, it holds the redirect target until the fetch completes.

Parameters:
CNT_W, 32, width of the saturating performance counters
XLEN, 32, PC / target width

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
i_req  in  1  I-cache request outstanding this cycle
i_resp  in  1  I-cache response valid this cycle
d_req  in  1  D-cache request from MEM stage
d_resp  in  1  D-cache response valid this cycle
id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
id_use_rs1, id_use_rs2  in  1 each  ID instruction reads rs1 / rs2
ex_rd  in  5  destination register of the instruction in EX
ex_is_load  in  1  instruction in EX is a load
ex_br_taken  in  1  EX resolves a taken branch or jump
ex_target  in  XLEN  redirect target from EX
load_pc  out  1  PC register enable
pc_sel  out  2  PC mux select: 0 = pc+4, 1 = ex_target, 2 = redirect_pc
redirect_pc  out  XLEN  latched redirect target
load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  pipe register enables
flush_if_id, flush_id_ex  out  1 each  load a NOP into that register instead of upstream data
stall_cycles  out  CNT_W  count of cycles with load_pc = 0 while out of reset
flush_events  out  CNT_W  count of cycles with flush_if_id = 1

Behaviour:
- Derived signals:
  - mem_busy = d_req & ~d_resp
  - fetch_busy = i_req & ~i_resp
  - load_use = ex_is_load & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd))
- State registers: redirect_pending (1 bit), redirect_pc (XLEN), stall_cycles, flush_events.
- All outputs are combinational from inputs and state. Zero-latency Mealy behaviour; decisions apply in the same cycle.
- While reset = 0:
  - All load_* = 0, flush_* = 0, pc_sel = 0.
  - redirect_pending = 0, redirect_pc = 0, both counters = 0.
  - Asserting reset mid-stall or with a redirect pending discards the pending redirect immediately.
- Per-cycle priority, highest first:
  1. mem_busy: all load_* = 0, flush_* = 0. Whole pipe freezes; ex_br_taken and load_use are ignored and re-evaluated next cycle.
  2. ex_br_taken & ~fetch_busy:
     - All load_* = 1, pc_sel = 1.
     - flush_if_id = 1, flush_id_ex = 1.
     - Any load_use in the same cycle is ignored; the branch wins.
  3. ex_br_taken & fetch_busy:
     - load_pc = 0, load_if_id = 0.
     - load_id_ex = load_ex_mem = load_mem_wb = 1, flush_id_ex = 1.
     - Latch redirect_pc <= ex_target and redirect_pending <= 1. A second latch while pending overwrites the target.
  4. fetch_busy: load_pc = 0, load_if_id = 0, load_id_ex = 1 with flush_id_ex = 1, load_ex_mem = load_mem_wb = 1.
  5. load_use: same enables as case 4. Exactly one bubble per hazard, because the load advances to MEM.
  6. Otherwise, all load_* = 1 and pc_sel = 0.
     - If redirect_pending: pc_sel = 2 and flush_if_id = 1 (discards the wrong-path instruction just fetched); clear redirect_pending.
- Counters:
  - Increment by 1 on the clock edge when the condition holds.
  - Saturate at all-ones; no wrap.
- The caller guarantees i_resp and d_resp are only asserted alongside the matching req. A resp without a req is a don't-care; no state changes from it.

Test Plan:
1. Reset: drive reset = 0 with all inputs active -> all load_* = 0, counters = 0. Release with idle inputs -> all load_* = 1, pc_sel = 0.
2. D-cache miss: d_req = 1, d_resp = 0 for 3 cycles, then d_resp = 1 -> all enables 0 for 3 cycles and 1 on the 4th; stall_cycles = 3.
3. Load-use: ex_is_load = 1, ex_rd = 5, id_rs2 = 5, id_use_rs2 = 1 -> one cycle with load_pc = 0, load_if_id = 0, flush_id_ex = 1. Repeat with ex_rd = 0 -> no stall.
4. Branch with no miss: ex_br_taken = 1, ex_target = 0x60 -> pc_sel = 1, flush_if_id = 1, flush_id_ex = 1; flush_events increments to 1.
5. Branch during a fetch miss: i_req = 1, i_resp = 0, ex_br_taken = 1, ex_target = 0x80 -> redirect_pc = 0x80, pending set. Two cycles later i_resp = 1 -> pc_sel = 2, flush_if_id = 1, pending cleared.
6. Simultaneous d-miss and branch: mem_busy = 1 with ex_br_taken = 1 -> full freeze. Next cycle d_resp = 1 -> redirect with pc_sel = 1. Also pulse reset low while pending -> pending cleared, pc_sel = 0 after release.
